// File: rtl/mpu_stream_transpose_if.sv
// Stream bus for mpu_stream_transpose: row-major element input, element output, per-matrix mode.
interface mpu_stream_transpose_if #(
    parameter int unsigned WIDTH = 8
);
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    // Producer/consumer side: feeds matrices in and accepts the reordered stream.
    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    // Transpose block side.
    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/mpu_stream_transpose.sv
// Streaming NxN matrix transpose (or pass-through) with a registered output stage.
// Optional: define MPU_TRANSPOSE_PINGPONG_EN for two banks (fill one while the other drains);
// otherwise a single bank is used and input stalls while a matrix drains.
module mpu_stream_transpose #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 5
) (
    input logic                   clk,
    input logic                   rst_n,
    mpu_stream_transpose_if.slave bus
);
`ifdef MPU_TRANSPOSE_PINGPONG_EN
    localparam int unsigned NB = 2;
`else
    localparam int unsigned NB = 1;
`endif
    localparam bit          PP  = (NB == 2);
    localparam int unsigned NE  = N * N;
    localparam int unsigned CW  = $clog2(N);
    localparam int unsigned AW  = $clog2(NE);
    localparam int unsigned MAW = $clog2(NB * NE);

    typedef enum logic [1:0] {BkEmpty, BkFilling, BkFull, BkDraining} bank_st_e;

    // Bank 1 state is always present but stays EMPTY when only one bank is built.
    logic [WIDTH-1:0] mem [NB*NE];
    bank_st_e         bank_st_q [2];
    bank_st_e         bank_st_d [2];
    logic             bank_mode_q [2];
    logic             init_q;
    logic             wr_bank_q, rd_bank_q;
    logic [CW-1:0]    wr_r_q, wr_c_q, rd_i_q, rd_j_q;
    logic             out_valid_q, out_last_q;
    logic [WIDTH-1:0] out_data_q;

    logic             wr_fire, wr_first, wr_last;
    logic             rd_release, can_load, load, rd_at_last;
    logic             src_bank, src_avail;
    logic [AW-1:0]    wr_addr, rd_addr;

    function automatic logic [AW-1:0] lin_addr(input logic [CW-1:0] row, input logic [CW-1:0] col);
        return AW'(32'(row) * N + 32'(col));
    endfunction

    function automatic logic [MAW-1:0] mem_idx(input logic bank, input logic [AW-1:0] addr);
        return MAW'(32'(bank) * NE + 32'(addr));
    endfunction

    assign bus.in_ready  = init_q && (bank_st_q[wr_bank_q] == BkEmpty ||
                                      bank_st_q[wr_bank_q] == BkFilling);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

    // Handshake decode and selection of the bank feeding the output register.
    always_comb begin
        wr_fire    = bus.in_valid && bus.in_ready;
        wr_first   = (wr_r_q == '0) && (wr_c_q == '0);
        wr_last    = (wr_r_q == CW'(N - 1)) && (wr_c_q == CW'(N - 1));
        wr_addr    = lin_addr(wr_r_q, wr_c_q);
        rd_release = out_valid_q && bus.out_ready && out_last_q;
        can_load   = !out_valid_q || bus.out_ready;
        // Once the last element of the draining bank leaves, the next element comes from the
        // other bank so back-to-back matrices flow without a bubble.
        src_bank   = (rd_release && PP) ? ~rd_bank_q : rd_bank_q;
        // Element 0 sits at address 0, so it can be read the same cycle the bank completes.
        src_avail  = (bank_st_q[src_bank] == BkFull) ||
                     (wr_fire && wr_last && wr_bank_q == src_bank) ||
                     (bank_st_q[src_bank] == BkDraining && !out_last_q);
        load       = can_load && src_avail;
        rd_at_last = (rd_i_q == CW'(N - 1)) && (rd_j_q == CW'(N - 1));
        rd_addr    = bank_mode_q[src_bank] ? lin_addr(rd_i_q, rd_j_q) : lin_addr(rd_j_q, rd_i_q);
    end

    // Bank life cycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_st_d[1'(b)] = bank_st_q[1'(b)];
            if (wr_fire && wr_bank_q == 1'(b)) begin
                if (wr_last) begin
                    bank_st_d[1'(b)] = BkFull;
                end else if (wr_first) begin
                    bank_st_d[1'(b)] = BkFilling;
                end
            end
            if (load && src_bank == 1'(b) && bank_st_d[1'(b)] == BkFull) begin
                bank_st_d[1'(b)] = BkDraining;
            end
            if (rd_release && rd_bank_q == 1'(b)) begin
                bank_st_d[1'(b)] = BkEmpty;
            end
        end
    end

    // Control state: write/read counters, bank pointers and the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q      <= 1'b0;
            bank_st_q   <= '{default: BkEmpty};
            bank_mode_q <= '{default: 1'b0};
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_r_q      <= '0;
            wr_c_q      <= '0;
            rd_i_q      <= '0;
            rd_j_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            init_q    <= 1'b1;
            bank_st_q <= bank_st_d;
            if (wr_fire) begin
                if (wr_first) begin
                    bank_mode_q[wr_bank_q] <= bus.mode;
                end
                if (wr_c_q == CW'(N - 1)) begin
                    wr_c_q <= '0;
                    wr_r_q <= wr_last ? '0 : wr_r_q + 1'b1;
                end else begin
                    wr_c_q <= wr_c_q + 1'b1;
                end
                if (wr_last && PP) begin
                    wr_bank_q <= ~wr_bank_q;
                end
            end
            if (rd_release && PP) begin
                rd_bank_q <= ~rd_bank_q;
            end
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mem[mem_idx(src_bank, rd_addr)];
                out_last_q  <= rd_at_last;
                if (rd_j_q == CW'(N - 1)) begin
                    rd_j_q <= '0;
                    rd_i_q <= rd_at_last ? '0 : rd_i_q + 1'b1;
                end else begin
                    rd_j_q <= rd_j_q + 1'b1;
                end
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    // Element storage; no reset needed because bank flags gate every read.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[mem_idx(wr_bank_q, wr_addr)] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_mpu_stream_transpose.sv
// Bench for mpu_stream_transpose: N=3 and N=5 instances, scoreboard of expected output order.
module tb_mpu_stream_transpose;
    localparam int unsigned W = 8;
    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stall_cycles = 0;
    exp_t q3[$];
    exp_t q5[$];
    int   acc3[$];

    mpu_stream_transpose_if #(.WIDTH(W)) b3 ();
    mpu_stream_transpose_if #(.WIDTH(W)) b5 ();

    mpu_stream_transpose #(.WIDTH(W), .N(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    mpu_stream_transpose #(.WIDTH(W), .N(5)) u5 (.clk(clk), .rst_n(rst_n), .bus(b5));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends count elements base, base+1, ...; queues the expected output order when push is set.
    task automatic send(input bit five, input logic [W-1:0] base, input logic m, input int count,
                        input bit push, input bit chk_lat);
        int n = five ? 5 : 3;
        bit hs;
        int tmo;
        if (push) begin
            for (int k = 0; k < n * n; k++) begin
                exp_t e;
                e.data = m ? base + W'(k) : base + W'((k % n) * n + (k / n));
                e.last = (k == n * n - 1);
                if (five) q5.push_back(e);
                else q3.push_back(e);
            end
        end
        for (int k = 0; k < count; k++) begin
            if (five) begin
                b5.in_valid = 1'b1; b5.in_data = base + W'(k); b5.mode = m;
            end else begin
                b3.in_valid = 1'b1; b3.in_data = base + W'(k); b3.mode = m;
            end
            if (chk_lat && k == count - 1) check("latency_before_last_in", b3.out_valid, 0);
            tmo = 0;
            do begin
                hs = five ? b5.in_ready : b3.in_ready;
                step();
                if (!hs) stall_cycles++;
                tmo++;
            end while (!hs && tmo < 100);
            if (!hs) begin
                check("in_ready_timeout", five ? b5.in_ready : b3.in_ready, 1);
                break;
            end
        end
        b3.in_valid = 1'b0;
        b5.in_valid = 1'b0;
        if (chk_lat) check("latency_after_last_in", b3.out_valid, 1);
    endtask

    // Runs until the scoreboard is empty and the output idles; bp applies out_ready 1,0,0,1.
    task automatic drain(input bit five, input bit bp);
        int c = 0;
        while ((five ? (q5.size() != 0 || b5.out_valid) : (q3.size() != 0 || b3.out_valid))
               && c < 400) begin
            if (bp) b3.out_ready = (c % 4 == 0) || (c % 4 == 3);
            step();
            c++;
        end
        b3.out_ready = 1'b1;
        if (c >= 400) check("drain_timeout", five ? b5.out_valid : b3.out_valid, 0);
        check(five ? "u5_queue_empty" : "u3_queue_empty", five ? q5.size() : q3.size(), 0);
    endtask

    // Output monitor: scoreboard compare on every accepted element, hold check while stalled.
    initial begin
        bit           pend3;
        logic [W-1:0] hold_d;
        logic         hold_l;
        exp_t         e;
        pend3 = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pend3 = 1'b0;
            end else begin
                if (pend3) begin
                    check("u3_hold_valid", b3.out_valid, 1);
                    check("u3_hold_data", b3.out_data, hold_d);
                    check("u3_hold_last", b3.out_last, hold_l);
                end
                pend3  = b3.out_valid && !b3.out_ready;
                hold_d = b3.out_data;
                hold_l = b3.out_last;
                if (b3.out_valid && b3.out_ready) begin
                    acc3.push_back(cyc);
                    if (q3.size() == 0) begin
                        check("u3_spurious_out", b3.out_valid, 0);
                    end else begin
                        e = q3.pop_front();
                        check("u3_data", b3.out_data, e.data);
                        check("u3_last", b3.out_last, e.last);
                    end
                end
                if (b5.out_valid && b5.out_ready) begin
                    if (q5.size() == 0) begin
                        check("u5_spurious_out", b5.out_valid, 0);
                    end else begin
                        e = q5.pop_front();
                        check("u5_data", b5.out_data, e.data);
                        check("u5_last", b5.out_last, e.last);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s1;
        b3.in_valid = 1'b0; b3.in_data = '0; b3.mode = 1'b0; b3.out_ready = 1'b1;
        b5.in_valid = 1'b0; b5.in_data = '0; b5.mode = 1'b0; b5.out_ready = 1'b1;
        repeat (3) step();
        check("rst_in_ready", b3.in_ready, 0);
        check("rst_out_valid", b3.out_valid, 0);
        check("rst_out_data", b3.out_data, 0);
        check("rst_out_last", b3.out_last, 0);
        rst_n = 1'b1;
        #1;
        check("release_in_ready_low", b3.in_ready, 0);
        step();
        check("release_in_ready_high", b3.in_ready, 1);
        check("release_u5_in_ready", b5.in_ready, 1);

        // Transpose 1..9: 1,4,7,2,5,8,3,6,9 with latency and sustained rate checks.
        acc3.delete();
        send(1'b0, 8'd1, 1'b0, 9, 1'b1, 1'b1);
        drain(1'b0, 1'b0);
        check("t1_out_count", acc3.size(), 9);
        check("t1_contiguous", acc3[8] - acc3[0], 8);

        // Pass-through 1..9.
        send(1'b0, 8'd1, 1'b1, 9, 1'b1, 1'b0);
        drain(1'b0, 1'b0);

        // Backpressure while draining a transposed matrix.
        send(1'b0, 8'd40, 1'b0, 9, 1'b1, 1'b0);
        drain(1'b0, 1'b1);

        // N=5 signed elements -128..-104.
        send(1'b1, 8'h80, 1'b0, 25, 1'b1, 1'b0);
        drain(1'b1, 1'b0);

        // Two matrices back-to-back.
        acc3.delete();
        stall_cycles = 0;
        send(1'b0, 8'd10, 1'b0, 9, 1'b1, 1'b0);
        s1 = stall_cycles;
        send(1'b0, 8'd19, 1'b0, 9, 1'b1, 1'b0);
        drain(1'b0, 1'b0);
        check("b2b_out_count", acc3.size(), 18);
        check("b2b_first_stalls", s1, 0);
`ifdef MPU_TRANSPOSE_PINGPONG_EN
        check("b2b_in_ready_stalls", stall_cycles, 0);
        check("b2b_contiguous", acc3[17] - acc3[0], 17);
`else
        check("b2b_in_ready_stalls", stall_cycles - s1, 9);
        check("b2b_gap_after_ninth", acc3[9] - acc3[8], 10);
`endif

        // Reset with a held output matrix, then with a partial input matrix.
        b3.out_ready = 1'b0;
        send(1'b0, 8'd50, 1'b0, 9, 1'b0, 1'b0);
        check("held_out_valid", b3.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", b3.out_valid, 0);
        check("midrst_out_last", b3.out_last, 0);
        check("midrst_out_data", b3.out_data, 0);
        check("midrst_in_ready", b3.in_ready, 0);
        step();
        rst_n = 1'b1;
        b3.out_ready = 1'b1;
        step();
        send(1'b0, 8'd60, 1'b0, 4, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("partial_rst_out_valid", b3.out_valid, 0);
        step();
        rst_n = 1'b1;
        step();
        send(1'b0, 8'd1, 1'b0, 9, 1'b1, 1'b0);
        drain(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
